// File: rtl/writeback_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_register_file
//  Purpose  : Write-back end of the MEM/WB pipeline interface. Selects the
//             write-back value (load data or ALU result), commits it into a
//             NUM_REGS x DATA_W MIPS register file and exposes two
//             combinational read ports for the ID stage. Also tracks a
//             committed-write counter and the PC of the last retired write.
//
//  Ports    : Clk             rising-edge clock
//             Rst             synchronous active-high reset
//             regWrite_in     MEM/WB write enable
//             memToReg_in     1 = write readData_in, 0 = write ALUResult_in
//             readData_in     load value from MEM/WB
//             ALUResult_in    ALU result from MEM/WB
//             regDstMux_in    destination register number
//             myPC_in         PC of the instruction in write-back
//             readReg1_in     ID read address, port 1
//             readReg2_in     ID read address, port 2
//             readData1_out   read port 1 data (combinational)
//             readData2_out   read port 2 data (combinational)
//             writeData_out   selected write-back value (combinational)
//             lastWritePC_out PC of the most recent committed write
//             wbCount_out     count of committed writes (wraps)
//
//  Options  : WB_READ_BYPASS_EN - when defined, a read of the register being
//             committed this cycle returns the incoming write-back value
//             (write-first). When undefined, reads return stored contents.
//
//  Revision : 1.0  initial release
// ============================================================================
module writeback_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        regWrite_in,
  input  logic                        memToReg_in,
  input  logic [DATA_W-1:0]           readData_in,
  input  logic [DATA_W-1:0]           ALUResult_in,
  input  logic [$clog2(NUM_REGS)-1:0] regDstMux_in,
  input  logic [31:0]                 myPC_in,
  input  logic [$clog2(NUM_REGS)-1:0] readReg1_in,
  input  logic [$clog2(NUM_REGS)-1:0] readReg2_in,
  output logic [DATA_W-1:0]           readData1_out,
  output logic [DATA_W-1:0]           readData2_out,
  output logic [DATA_W-1:0]           writeData_out,
  output logic [31:0]                 lastWritePC_out,
  output logic [CNT_W-1:0]            wbCount_out
);

  localparam int unsigned c_ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [31:0]         r_lastWritePC;
  logic [CNT_W-1:0]    r_wbCount;

  logic [DATA_W-1:0]   w_writeData;
  logic                w_commit;
  logic [DATA_W-1:0]   w_read1;
  logic [DATA_W-1:0]   w_read2;

  // Write-back mux is independent of regWrite_in so the forwarding unit
  // always sees the value that would be written.
  assign w_writeData = memToReg_in ? readData_in : ALUResult_in;

  // Writes aimed at $zero are architecturally discarded.
  assign w_commit = regWrite_in && (regDstMux_in != '0);

  // --------------------------------------------------------------------------
  // State: register array, last-write PC, commit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
      r_lastWritePC <= '0;
      r_wbCount     <= '0;
    end else if (w_commit) begin
      r_regs[regDstMux_in] <= w_writeData;
      r_lastWritePC        <= myPC_in;
      r_wbCount            <= r_wbCount + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Address 0 is forced to zero regardless of array contents.
  // --------------------------------------------------------------------------
  always_comb begin
    w_read1 = '0;
    if (readReg1_in != c_ADDR_W'(0)) begin
      w_read1 = r_regs[readReg1_in];
`ifdef WB_READ_BYPASS_EN
      // Write-first: the value being committed this cycle wins over storage.
      if (w_commit && (regDstMux_in == readReg1_in)) begin
        w_read1 = w_writeData;
      end
`endif
    end
  end

  always_comb begin
    w_read2 = '0;
    if (readReg2_in != c_ADDR_W'(0)) begin
      w_read2 = r_regs[readReg2_in];
`ifdef WB_READ_BYPASS_EN
      if (w_commit && (regDstMux_in == readReg2_in)) begin
        w_read2 = w_writeData;
      end
`endif
    end
  end

  assign readData1_out   = w_read1;
  assign readData2_out   = w_read2;
  assign writeData_out   = w_writeData;
  assign lastWritePC_out = r_lastWritePC;
  assign wbCount_out     = r_wbCount;

endmodule
`default_nettype wire
